// File: rtl/sdf_ctrl.sv
// Frame sequencer for a radix-2 SDF NTT pipeline: input requests, per-stage
// butterfly/bypass selects and twiddle addresses, and the bit-reversed output window.
module sdf_ctrl #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned bf_lat     = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  output logic                                  busy_o,
  output logic                                  in_req_o,
  output logic [addr_width-1:0]                 in_idx_o,
  output logic [addr_width-1:0]                 bf_sel_o,
  output logic [addr_width*(addr_width-1)-1:0]  tw_addr_o,
  output logic                                  out_valid_o,
  output logic [addr_width-1:0]                 out_idx_o,
  output logic                                  done_tick_o
);

  localparam int unsigned N      = 1 << addr_width;
  localparam int unsigned LAT    = N - 1 + addr_width * bf_lat;
  localparam int unsigned LAST_G = LAT + N - 1;
  localparam int unsigned GW     = $clog2(LAT + N);
  localparam int unsigned AW     = addr_width;
  localparam int unsigned TW     = addr_width - 1;
  localparam int unsigned TWW    = addr_width * TW;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;

  logic            busy_d;
  logic            in_req_d;
  logic [AW-1:0]   in_idx_d;
  logic [AW-1:0]   bf_sel_d;
  logic [TWW-1:0]  tw_addr_d;
  logic            out_valid_d;
  logic [AW-1:0]   out_idx_d;
  logic            done_tick_d;

  // Frame state and global counter; g is cleared whenever a frame is not running.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        g_d     = '0;
      end
    end else begin
      if (g_q == GW'(LAST_G)) begin
        state_d = IDLE;
        g_d     = '0;
      end else begin
        g_d = g_q + GW'(1);
      end
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the cycle the state/counter describe.
  always_comb begin
    logic            run;
    logic [GW-1:0]   ofs;
    logic [GW-1:0]   c;
    int unsigned     off;

    run         = (state_d == RUN);
    busy_d      = run;
    in_req_d    = run && (g_d < GW'(N));
    in_idx_d    = g_d[AW-1:0];
    out_valid_d = run && (g_d >= GW'(LAT));
    done_tick_d = run && (g_d == GW'(LAST_G));

    ofs       = g_d - GW'(LAT);
    out_idx_d = '0;
    if (out_valid_d) begin
      for (int i = 0; i < int'(AW); i++) begin
        out_idx_d[i] = ofs[int'(AW) - 1 - i];
      end
    end

    // Stage s fills for D_s cycles then runs butterflies for D_s cycles;
    // the active-window compare keeps g < off_s from wrapping into a hit.
    bf_sel_d  = '0;
    tw_addr_d = '0;
    off       = 0;
    c         = '0;
    for (int s = 0; s < int'(AW); s++) begin
      c = g_d - GW'(off);
      if (run && (g_d >= GW'(off)) && (g_d < GW'(off + N)) && c[int'(AW) - 1 - s]) begin
        bf_sel_d[s]             = 1'b1;
        tw_addr_d[s*TW +: TW]   = TW'((c & GW'((N >> (s + 1)) - 1)) << s);
      end
      off = off + (N >> (s + 1)) + bf_lat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      g_q         <= '0;
      busy_o      <= 1'b0;
      in_req_o    <= 1'b0;
      in_idx_o    <= '0;
      bf_sel_o    <= '0;
      tw_addr_o   <= '0;
      out_valid_o <= 1'b0;
      out_idx_o   <= '0;
      done_tick_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      busy_o      <= busy_d;
      in_req_o    <= in_req_d;
      in_idx_o    <= in_idx_d;
      bf_sel_o    <= bf_sel_d;
      tw_addr_o   <= tw_addr_d;
      out_valid_o <= out_valid_d;
      out_idx_o   <= out_idx_d;
      done_tick_o <= done_tick_d;
    end
  end

endmodule

// File: doc/sdf_ctrl.md
# sdf_ctrl

Frame sequencer for the radix-2 single-path delay feedback (SDF) NTT pipeline. On a `start` pulse it requests the `2**addr_width` input samples and drives each stage's butterfly/bypass select and twiddle ROM address. It then flags the bit-reversed output window and pulses `done_tick` on the last output sample. It sits beside the SDF datapath and drives its control inputs; the datapath itself carries no counters.

## Interface
- `addr_width`, default 4: log2 of the transform size. N = 2**addr_width. The pipeline has `addr_width` stages.
- `bf_lat`, default 1: register latency of one stage's butterfly/modular reduction path, in cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame request. Sampled only in IDLE.
- `busy` out 1: high while a frame is in flight.
- `in_req` out 1: upstream must present sample `in_idx` on the datapath input this cycle.
- `in_idx` out addr_width: natural-order index of the requested input sample.
- `bf_sel` out addr_width: bit s = 1 puts stage s in butterfly mode; 0 puts it in fill/bypass mode.
- `tw_addr` out addr_width*(addr_width-1): twiddle ROM address. Stage s uses slice [s*(addr_width-1) +: addr_width-1].
- `out_valid` out 1: the datapath output is a valid result this cycle.
- `out_idx` out addr_width: index of the current output coefficient. Outputs arrive in bit-reversed order.
- `done_tick` out 1: one-cycle pulse, coincident with the last `out_valid`.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE → RUN when `start`=1. The global counter g is cleared to 0.
  - RUN increments g by 1 every cycle.
  - RUN → IDLE after the cycle with g = LAT+N-1.
  - `start` is ignored in RUN, including in the `done_tick` cycle.
- Derived constants:
  - Stage delay D_s = N >> (s+1).
  - Stage offset off_s = sum over k<s of (D_k + bf_lat).
  - Pipeline latency LAT = off_{addr_width} = N-1 + addr_width*bf_lat. With defaults, LAT = 19 and off = 0, 9, 14, 17.
- Input side:
  - `in_req` = RUN && g < N.
  - `in_idx` = g[addr_width-1:0].
- Stage s runs on a local counter c_s = g - off_s.
  - It is active when off_s <= g < off_s + N.
  - `bf_sel[s]` = active && c_s[addr_width-1-s]. Each stage fills for D_s cycles, then runs butterflies for D_s cycles.
  - `tw_addr` slice s = (c_s mod D_s) << s when `bf_sel[s]`=1, else 0. The last stage's slice is always 0.
- Output side:
  - `out_valid` = RUN && g >= LAT.
  - `out_idx` = bit-reverse of (g - LAT)[addr_width-1:0].
  - `done_tick` = RUN && g == LAT+N-1.
- `busy` = (state == RUN).
- All outputs are combinational decodes of the state and g, so they change together with no glitch-visible ordering requirement.
- g width is ceil(log2(LAT+N)) bits. It has no wrap-around within a frame. Subtractions are computed so that g < off_s never produces a spurious active stage.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- `rst` during RUN: the next cycle is IDLE with all outputs 0. No `done_tick` is issued. The partial frame is discarded.
- `rst` and `start` in the same cycle: reset wins.
- `start` sampled high at edge E: the cycle after E has g = 0, `busy`=1 and `in_req`=1.
- A frame occupies exactly LAT+N cycles (35 with defaults).
- `start` held high continuously gives frames separated by exactly one IDLE cycle.
- The input and output windows of one frame never overlap a second frame.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0 and `busy`=0 throughout.
- Single `start` pulse with defaults:
  - `in_req` high for g = 0..15 with `in_idx` = 0..15.
  - `out_valid` high for g = 19..34.
  - `done_tick` only at g = 34.
  - `busy` falls at the next cycle.
- Stage controls:
  - `bf_sel[0]` high at g = 8..15, with stage-0 `tw_addr` = 0..7.
  - `bf_sel[1]` high at g = 13..16 and 21..24, with `tw_addr` = 0, 2, 4, 6.
  - `bf_sel[3]` high at odd c_3, i.e. g = 18, 20, ..., 32, with `tw_addr` = 0.
- Output order: `out_idx` over g = 19..34 = 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15.
- `start` pulses at g = 5 and g = 34 are ignored. `start` held high gives a second frame whose g = 0 comes 2 cycles after the first `done_tick`.
- `rst` at g = 10: outputs are 0 the next cycle and no `done_tick` ever appears. A later `start` produces a complete, correct 35-cycle frame.
